// File: rtl/load_align_queue.sv
// Load-result alignment stage: extracts the addressed byte lane(s) from a memory
// word, sign/zero-extends, flags misaligned loads and queues results in a 2-entry FIFO.
module load_align_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8,
   localparam int LANE_BITS = $clog2(DATA_WIDTH / 8)
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [LANE_BITS-1:0]  MemAdr,
   input  logic [DATA_WIDTH-1:0] MemData,
   input  logic [1:0]            LdSize,
   input  logic                  LdUnsigned,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [DATA_WIDTH-1:0] OutData,
   output logic                  OutMisalign,
   output logic [CNT_WIDTH-1:0]  MisalignCount
);

   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] aligned;
   logic                  msb;
   logic                  misalign;
   logic                  push;
   logic                  pop;

   logic [DATA_WIDTH-1:0] data_q [2];
   logic                  mis_q  [2];
   logic                  wr_q;
   logic                  rd_q;
   logic [1:0]            occ_q;
   logic [1:0]            occ_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;

   // Lane field is moved to bit 0 first, then masked and extended by size.
   always_comb begin
      shifted  = MemData >> {MemAdr, 3'b000};
      mask     = '1;
      msb      = shifted[DATA_WIDTH-1];
      misalign = 1'b0;
      unique case (LdSize)
         2'd0: begin
            mask = DATA_WIDTH'(64'hFF);
            msb  = shifted[7];
         end
         2'd1: begin
            mask     = DATA_WIDTH'(64'hFFFF);
            msb      = shifted[15];
            misalign = MemAdr[0];
         end
         2'd2: begin
            mask     = DATA_WIDTH'(64'hFFFF_FFFF);
            msb      = shifted[31];
            misalign = |MemAdr[1:0];
         end
         default: begin
            mask     = '1;
            msb      = shifted[DATA_WIDTH-1];
            misalign = (DATA_WIDTH == 32) || (|MemAdr);
         end
      endcase
      aligned = (~LdUnsigned & msb) ? (shifted | ~mask) : (shifted & mask);
      if (misalign) begin
         aligned = '0;
      end
   end

   assign InReady  = Rst_n && (occ_q != 2'd2);
   assign OutValid = (occ_q != 2'd0);
   assign push     = InValid && InReady;
   assign pop      = OutValid && OutReady;

   always_comb begin
      occ_d = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + 2'd1;
      end else if (pop && !push) begin
         occ_d = occ_q - 2'd1;
      end
      cnt_d = cnt_q;
      if (push && misalign && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            mis_q[i]  <= 1'b0;
         end
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         occ_q <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            data_q[wr_q] <= aligned;
            mis_q[wr_q]  <= misalign;
            wr_q         <= ~wr_q;
         end
         if (pop) begin
            rd_q <= ~rd_q;
         end
         occ_q <= occ_d;
         cnt_q <= cnt_d;
      end
   end

   assign OutData       = OutValid ? data_q[rd_q] : '0;
   assign OutMisalign   = OutValid & mis_q[rd_q];
   assign MisalignCount = cnt_q;

endmodule

// File: tb/tb_load_align_queue.sv
// Bench for load_align_queue: a 32-bit/2-bit-counter and a 64-bit/8-bit-counter
// instance checked against an arithmetic load model with an expected-result queue.
module tb_load_align_queue;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;
   logic Rst_n;

   logic        iv0, ir0, ov0, or0, om0, un0;
   logic [1:0]  ad0, sz0, mc0;
   logic [31:0] md0, od0;

   logic        iv1, ir1, ov1, or1, om1, un1;
   logic [2:0]  ad1;
   logic [1:0]  sz1;
   logic [7:0]  mc1;
   logic [63:0] md1, od1;

   load_align_queue #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u32 (
      .Clk(Clk), .Rst_n(Rst_n), .InValid(iv0), .InReady(ir0), .MemAdr(ad0),
      .MemData(md0), .LdSize(sz0), .LdUnsigned(un0), .OutValid(ov0),
      .OutReady(or0), .OutData(od0), .OutMisalign(om0), .MisalignCount(mc0)
   );

   load_align_queue #(.DATA_WIDTH(64), .CNT_WIDTH(8)) u64 (
      .Clk(Clk), .Rst_n(Rst_n), .InValid(iv1), .InReady(ir1), .MemAdr(ad1),
      .MemData(md1), .LdSize(sz1), .LdUnsigned(un1), .OutValid(ov1),
      .OutReady(or1), .OutData(od1), .OutMisalign(om1), .MisalignCount(mc1)
   );

   int checks = 0;
   int errors = 0;

   // Expected-result queues, {data[63:0], misalign}
   logic [64:0] mq0[$];
   logic [64:0] mq1[$];
   int cnt_m[2];

   function automatic logic [64:0] ref_load(input int dw, input logic [63:0] md,
                                            input int adr, input int sz, input bit uns);
      int nb;
      logic [63:0] f, m;
      bit mis;
      nb  = 8 << sz;
      mis = ((adr % (1 << sz)) != 0) || (sz == 3 && dw == 32);
      if (mis) return {64'd0, 1'b1};
      f = md >> (8 * adr);
      m = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
      f = f & m;
      if (!uns && ((f >> (nb - 1)) & 64'd1) != 64'd0) f = f | ~m;
      if (dw == 32) f = f & 64'hFFFF_FFFF;
      return {f, 1'b0};
   endfunction

   function automatic int msize(input int d);
      return (d == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [64:0] mhead(input int d);
      if (msize(d) == 0) return '0;
      return (d == 0) ? mq0[0] : mq1[0];
   endfunction

   function automatic int cmax(input int d);
      return (d == 0) ? 3 : 255;
   endfunction

   task automatic get_obs(input int d, output bit v, output logic [63:0] data,
                          output bit mis, output bit rdy, output int cnt);
      if (d == 0) begin
         v = ov0; data = {32'd0, od0}; mis = om0; rdy = ir0; cnt = int'(mc0);
      end else begin
         v = ov1; data = od1; mis = om1; rdy = ir1; cnt = int'(mc1);
      end
   endtask

   // Drives one cycle into DUT d (other DUT idles), then advances the model.
   task automatic cycle(input int d, input bit v, input int a, input int sz,
                        input bit u, input logic [63:0] md, input bit ordy);
      bit acc, pp;
      logic [64:0] r;
      if (d == 0) begin
         iv0 = v; ad0 = a[1:0]; sz0 = sz[1:0]; un0 = u; md0 = md[31:0]; or0 = ordy;
         iv1 = 1'b0; or1 = 1'b0;
         r = ref_load(32, {32'd0, md[31:0]}, a, sz, u);
      end else begin
         iv1 = v; ad1 = a[2:0]; sz1 = sz[1:0]; un1 = u; md1 = md; or1 = ordy;
         iv0 = 1'b0; or0 = 1'b0;
         r = ref_load(64, md, a, sz, u);
      end
      acc = v && (msize(d) < 2);
      pp  = ordy && (msize(d) > 0);
      @(posedge Clk);
      #1;
      if (pp) begin
         if (d == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (acc) begin
         if (d == 0) mq0.push_back(r); else mq1.push_back(r);
         if (r[0] && cnt_m[d] < cmax(d)) cnt_m[d]++;
      end
   endtask

   task automatic test_reset();
      bit v, mis, rdy;
      logic [63:0] data;
      int cnt;
      Rst_n = 1'b0;
      iv0 = 0; or0 = 0; ad0 = '0; sz0 = '0; un0 = 0; md0 = '0;
      iv1 = 0; or1 = 0; ad1 = '0; sz1 = '0; un1 = 0; md1 = '0;
      repeat (2) @(posedge Clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         get_obs(d, v, data, mis, rdy, cnt);
         checks++;
         if (v !== 1'b0 || data !== 64'd0 || mis !== 1'b0 || rdy !== 1'b0 || cnt != 0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got v=%0b d=%h m=%0b rdy=%0b cnt=%0d want all 0",
                     d, v, data, mis, rdy, cnt);
         end
      end
      Rst_n = 1'b1;
      mq0.delete(); mq1.delete();
      cnt_m[0] = 0; cnt_m[1] = 0;
   endtask

   task automatic test_extract_32();
      logic [63:0] want [4];
      bit          wmis [4];
      int          adr  [4];
      int          sz   [4];
      bit          uns  [4];
      want = '{64'hFFFF_FFF0, 64'h0000_00F0, 64'hFFFF_8034, 64'h0};
      wmis = '{1'b0, 1'b0, 1'b0, 1'b1};
      adr  = '{0, 0, 2, 1};
      sz   = '{0, 0, 1, 1};
      uns  = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) begin
         cycle(0, 1'b1, adr[k], sz[k], uns[k], 64'h8034_12F0, 1'b1);
         checks++;
         if (ov0 !== 1'b1 || {32'd0, od0} !== want[k] || om0 !== wmis[k]) begin
            errors++;
            $display("FAIL extract32_%0d: got v=%0b d=%h m=%0b want v=1 d=%h m=%0b",
                     k, ov0, od0, om0, want[k][31:0], wmis[k]);
         end
      end
      checks++;
      if (mc0 !== 2'd1) begin
         errors++;
         $display("FAIL extract32_count: got %0d want 1", mc0);
      end
      cycle(0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
      checks++;
      if (ov0 !== 1'b0 || od0 !== 32'd0 || om0 !== 1'b0) begin
         errors++;
         $display("FAIL idle_zero32: got v=%0b d=%h m=%0b want 0", ov0, od0, om0);
      end
   endtask

   task automatic test_extract_64();
      cycle(1, 1'b1, 4, 2, 1'b0, 64'h89AB_CDEF_0123_4567, 1'b1);
      checks++;
      if (ov1 !== 1'b1 || od1 !== 64'hFFFF_FFFF_89AB_CDEF || om1 !== 1'b0) begin
         errors++;
         $display("FAIL extract64_word_hi: got v=%0b d=%h m=%0b want v=1 d=ffffffff89abcdef m=0",
                  ov1, od1, om1);
      end
      cycle(1, 1'b1, 0, 3, 1'b0, 64'h89AB_CDEF_0123_4567, 1'b1);
      checks++;
      if (ov1 !== 1'b1 || od1 !== 64'h89AB_CDEF_0123_4567 || om1 !== 1'b0) begin
         errors++;
         $display("FAIL extract64_dword: got v=%0b d=%h m=%0b want v=1 d=89abcdef01234567 m=0",
                  ov1, od1, om1);
      end
      cycle(1, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
      checks++;
      if (ov1 !== 1'b0 || od1 !== 64'd0) begin
         errors++;
         $display("FAIL idle_zero64: got v=%0b d=%h want 0", ov1, od1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [3];
      w = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
      for (int k = 0; k < 3; k++) begin
         cycle(0, 1'b1, 0, 2, 1'b1, {32'd0, w[k]}, 1'b0);
         if (k >= 1) begin
            checks++;
            if (ir0 !== 1'b0 || ov0 !== 1'b1 || od0 !== w[0]) begin
               errors++;
               $display("FAIL b2b_full_%0d: got rdy=%0b v=%0b d=%h want rdy=0 v=1 d=%h",
                        k, ir0, ov0, od0, w[0]);
            end
         end
      end
      cycle(0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
      checks++;
      if (ir0 !== 1'b1 || ov0 !== 1'b1 || od0 !== w[1]) begin
         errors++;
         $display("FAIL b2b_drain1: got rdy=%0b v=%0b d=%h want rdy=1 v=1 d=%h",
                  ir0, ov0, od0, w[1]);
      end
      cycle(0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
      checks++;
      if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drain2: got v=%0b rdy=%0b want v=0 rdy=1", ov0, ir0);
      end
   endtask

   task automatic test_random();
      bit v, mis, rdy;
      logic [63:0] data, md;
      logic [64:0] h;
      int cnt;
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 300; n++) begin
            md = {$urandom(), $urandom()};
            cycle(d, ($urandom_range(9) < 7), int'($urandom_range(d == 0 ? 3 : 7)),
                  int'($urandom_range(3)), bit'($urandom_range(1)), md,
                  ($urandom_range(9) < 6));
            get_obs(d, v, data, mis, rdy, cnt);
            h = mhead(d);
            checks++;
            if (v !== (msize(d) > 0) || rdy !== (msize(d) < 2) || data !== h[64:1] ||
                mis !== h[0] || cnt != cnt_m[d]) begin
               errors++;
               $display("FAIL random dut%0d cyc%0d: got v=%0b rdy=%0b d=%h m=%0b cnt=%0d want v=%0b rdy=%0b d=%h m=%0b cnt=%0d",
                        d, n, v, rdy, data, mis, cnt, msize(d) > 0, msize(d) < 2,
                        h[64:1], h[0], cnt_m[d]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int want;
      test_reset();
      for (int k = 0; k < 5; k++) begin
         cycle(0, 1'b1, 1, 1, 1'b0, {32'd0, $urandom()}, 1'b1);
         want = (k + 1 > 3) ? 3 : k + 1;
         checks++;
         if (int'(mc0) != want || om0 !== 1'b1 || od0 !== 32'd0) begin
            errors++;
            $display("FAIL saturate_%0d: got cnt=%0d m=%0b d=%h want cnt=%0d m=1 d=0",
                     k, mc0, om0, od0, want);
         end
      end
      cycle(0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
   endtask

   task automatic test_async_reset();
      cycle(0, 1'b1, 1, 1, 1'b0, 64'h1234, 1'b0);
      cycle(0, 1'b1, 3, 2, 1'b0, 64'h5678, 1'b0);
      checks++;
      if (ov0 !== 1'b1 || ir0 !== 1'b0 || mc0 === 2'd0) begin
         errors++;
         $display("FAIL async_prefill: got v=%0b rdy=%0b cnt=%0d want v=1 rdy=0 cnt>0",
                  ov0, ir0, mc0);
      end
      #2;
      Rst_n = 1'b0;
      #1;
      checks++;
      if (ov0 !== 1'b0 || mc0 !== 2'd0 || od0 !== 32'd0 || om0 !== 1'b0 || ir0 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got v=%0b cnt=%0d d=%h m=%0b rdy=%0b want all 0",
                  ov0, mc0, od0, om0, ir0);
      end
      mq0.delete(); mq1.delete();
      cnt_m[0] = 0; cnt_m[1] = 0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      cycle(0, 1'b1, 0, 0, 1'b1, 64'h55, 1'b1);
      checks++;
      if (ov0 !== 1'b1 || od0 !== 32'h55 || mc0 !== 2'd0) begin
         errors++;
         $display("FAIL first_accept: got v=%0b d=%h cnt=%0d want v=1 d=55 cnt=0",
                  ov0, od0, mc0);
      end
   endtask

   initial begin
      test_reset();
      test_extract_32();
      test_extract_64();
      test_back_to_back();
      test_random();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_align_queue.md
LOAD_ALIGN_QUEUE -- requirements
Module: load_align_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the memory word width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, the width of the misalignment counter.
REQ-003 The block SHALL have derived localparam LANE_BITS = log2(DATA_WIDTH/8), the number of byte-select address bits.
REQ-004 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have port InValid, input, 1 bit, load-result request present.
REQ-007 The block SHALL have port InReady, output, 1 bit, the block can accept a request this cycle.
REQ-008 The block SHALL have port MemAdr, input, LANE_BITS bits, low bits of the computed address (offset + base).
REQ-009 The block SHALL have port MemData, input, DATA_WIDTH bits, the full memory word read.
REQ-010 The block SHALL have port LdSize, input, 2 bits: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 The block SHALL have port LdUnsigned, input, 1 bit: 1 selects zero-extension, 0 sign-extension.
REQ-012 The block SHALL have port OutValid, output, 1 bit, a result is presented.
REQ-013 The block SHALL have port OutReady, input, 1 bit, the consumer takes the result.
REQ-014 The block SHALL have port OutData, output, DATA_WIDTH bits, the aligned and extended load result.
REQ-015 The block SHALL have port OutMisalign, output, 1 bit, the presented result is a misaligned or illegal load.
REQ-016 The block SHALL have port MisalignCount, output, CNT_WIDTH bits, a saturating count of misaligned loads accepted.

Function
REQ-017 The block SHALL hold a 2-entry FIFO of {OutData, OutMisalign}; a request is accepted when InValid && InReady.
REQ-018 The block SHALL drive InReady = (occupancy < 2); it SHALL NOT depend combinationally on OutReady.
REQ-019 The block SHALL drive OutValid = (occupancy > 0); an entry is popped when OutValid && OutReady.
REQ-020 On simultaneous push and pop, occupancy SHALL be unchanged; at occupancy 2 no push is possible; at occupancy 0 no pop occurs.
REQ-021 Latency SHALL be one cycle: a request accepted at edge N SHALL appear on OutData/OutValid after edge N when the FIFO was empty; ordering is strictly FIFO.
REQ-022 Extraction SHALL take lane field = MemData[8*MemAdr +: 8*bytes], where bytes = 1, 2, 4, 8 for LdSize 0..3.
REQ-023 Extension SHALL set the upper DATA_WIDTH - 8*bytes bits to 0 if LdUnsigned is 1, else to the field's MSB.
REQ-024 Misalignment SHALL occur when MemAdr mod bytes != 0, or when LdSize = 3 with DATA_WIDTH = 32; misaligned entries SHALL store OutData = 0 and OutMisalign = 1.
REQ-025 A word load with DATA_WIDTH = 64 SHALL use MemAdr[2] to select the half-word pair; at DATA_WIDTH = 32 a word load at MemAdr 0 SHALL pass MemData unchanged.
REQ-026 MisalignCount SHALL increment by 1 per accepted misaligned request and SHALL saturate at all-ones; it is never cleared except by reset.
REQ-027 OutData and OutMisalign SHALL be 0 whenever OutValid is 0.

Reset
REQ-028 On Rst_n low, regardless of Clk, the block SHALL clear occupancy, the FIFO pointers, entries and MisalignCount.
REQ-029 During reset, the block SHALL drive OutValid = 0, OutData = 0, OutMisalign = 0, InReady = 0.
REQ-030 The first accept SHALL be possible at the first rising edge after Rst_n deasserts; a transfer in flight when reset asserts SHALL be discarded without being counted.

Verification
REQ-031 The bench SHALL cover: DW=32, MemData=0x8034_12F0, MemAdr=0, LdSize=0, signed -> OutData=0xFFFF_FFF0 one cycle later; same with LdUnsigned=1 -> 0x0000_00F0.
REQ-032 The bench SHALL cover: DW=32, MemData=0x8034_12F0, MemAdr=2, LdSize=1, signed -> 0xFFFF_8034; MemAdr=1, LdSize=1 -> OutData=0, OutMisalign=1, MisalignCount=1.
REQ-033 The bench SHALL cover: DW=64, MemData=0x89AB_CDEF_0123_4567, MemAdr=4, LdSize=2, signed -> 0xFFFF_FFFF_89AB_CDEF; LdSize=3, MemAdr=0 -> the word unchanged.
REQ-034 The bench SHALL cover: OutReady held 0 with three back-to-back requests -> two accepted and InReady=0 on the third; OutReady raised -> results in order and InReady returns 1 the next cycle.
REQ-035 The bench SHALL cover: CNT_WIDTH=2 with five misaligned loads -> MisalignCount sticks at 3.
REQ-036 The bench SHALL cover: Rst_n asserted mid-cycle with occupancy 2 -> OutValid=0 and MisalignCount=0 immediately, without a clock edge.
